neuron_mac: RTL
===============

# neuron_mac

Serial multiply-accumulate stage computing one neuron's pre-activation sum `bias + Σ x[i]*w[i]` in signed QM.QN fixed point. One product per cycle. The saturated QM.QN result drives the `in` port of the downstream `Sigmoid` stage directly. Valid/ready handshakes on both sides let it sit in a layer pipeline between the input/weight buffers and the activation.

## Interface
- `N`, 2: inputs per neuron (≥1)
- `QM`, 6: integer bits, including sign
- `QN`, 10: fractional bits; operand width is W = QM+QN
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `in_valid`  input  1  operand bundle valid
- `in_ready`  output  1  block can accept a bundle
- `x`  input  N×W signed  activations, QM.QN
- `w`  input  N×W signed  weights, QM.QN
- `bias`  input  W signed  bias, QM.QN
- `out_valid`  output  1  `sum` valid
- `out_ready`  input  1  downstream accepts `sum`
- `sum`  output  W signed  saturated result, QM.QN; feeds `Sigmoid.in`

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: register `x` and `w`; set `acc` = sign-extended `bias` << QN; set `idx`=0; go to MAC.
- MAC:
  - Each cycle: `acc += x_r[idx]*w_r[idx]`, using a full-precision 2W-bit signed product.
  - `idx` increments each cycle.
  - On the cycle that adds `idx`=N-1, go to DONE.
- DONE:
  - `out_valid`=1.
  - `sum` = sat(`acc` >>> QN).
  - On `out_ready`, go to IDLE.
- Accumulator width: ACC_W = 2W + clog2(N+1). The accumulator never overflows, so saturation is applied only at the output.
- Rounding: arithmetic right shift, i.e. truncation toward −∞.
- Saturation bounds: [−2^(W−1), 2^(W−1)−1]. For defaults that is [−32768, 32767], i.e. −32.0 to +31.999.
- Operand registers hold their values during MAC. Changes on `x`/`w`/`bias` after acceptance have no effect.
- `in_ready` and `out_valid` are decoded from state only. They never depend combinationally on `in_valid` or `out_ready`.

## Timing
- Reset (async assert):
  - State=IDLE, `idx`=0, `acc`=0, `sum`=0, `out_valid`=0.
  - `in_ready`=1 once in IDLE.
  - No output glitches high during reset.
- Reset mid-MAC or mid-DONE: the operation is discarded immediately, with no output handshake.
- Latency:
  - Bundle accepted at edge t.
  - MAC occupies edges t+1..t+N.
  - `out_valid` is high from edge t+N onward.
- Throughput: one bundle per N+2 cycles when `out_ready` is held high.
- Backpressure: in DONE with `out_ready`=0, `sum` and `out_valid` stay stable and `in_ready` stays 0.
- DONE→IDLE takes one cycle. A new bundle is accepted no earlier than the cycle after the output handshake.
- `in_valid` is ignored while `in_ready`=0.

## Structure
- Shared package `nn_pkg` holds:
  - the `state_t` enum {IDLE, MAC, DONE};
  - width functions for W and ACC_W;
  - a `sat_qmqn` function (ACC_W → W saturate).
- `Sigmoid` reuses the same QM/QN constants from `nn_pkg`.
- No sub-module is needed: a single FSM, counter, multiplier and accumulator.
- The multiplier is an inferred `*` on two W-bit signed operands. One multiplier is shared across all N terms.

## Test plan
Defaults are N=2, QM=6, QN=10, so 1.0 = 1024.
- Basic: x={1024, 2048}, w={512, 256}, bias=256 → `sum`=1280 (1.25); `out_valid` rises at acceptance edge + 2.
- Positive saturation: x={31744, 31744}, w={31744, 31744}, bias=0 → `sum`=32767.
- Negative saturation: x={31744, 31744}, w={−31744, −31744} → `sum`=−32768.
- Truncation: x={1, 0}, w={1, 0}, bias=0 → `sum`=0; with x={−1, 0} → `sum`=−1.
- Backpressure and handshake:
  - Hold `out_ready`=0 for 5 cycles in DONE → `sum` stable, `in_ready`=0, `in_valid` pulses ignored.
  - Back-to-back bundles with `out_ready`=1 → one result every 4 cycles, in order.
- Reset mid-MAC: assert `rst` one cycle after acceptance → `out_valid`=0 and `sum`=0 asynchronously; after release, `in_ready`=1 and the next bundle computes correctly.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared QM.QN constants, FSM state type and width/saturation helpers for the neuron layer.
package nn_pkg;

    localparam int Q_M = 6;
    localparam int Q_N = 10;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    function automatic int qw(input int qm, input int qn);
        return qm + qn;
    endfunction

    function automatic int acc_w(input int w, input int n);
        return 2 * w + $clog2(n + 1);
    endfunction

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_qmqn(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// neuron_mac: serial multiply-accumulate computing sat(bias + sum x[i]*w[i]) in QM.QN,
// one product per cycle through a single shared multiplier.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int N  = 2,
    parameter int QM = Q_M,
    parameter int QN = Q_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*qw(QM, QN)-1:0]   x,
    input  logic [N*qw(QM, QN)-1:0]   w,
    input  logic [qw(QM, QN)-1:0]     bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [qw(QM, QN)-1:0]     sum
);

    localparam int W     = qw(QM, QN);
    localparam int ACC_W = acc_w(W, N);
    localparam int IW    = N > 1 ? $clog2(N) : 1;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [W-1:0]             sum_q, sum_d;
    logic [N*W-1:0]           x_q, x_d, w_q, w_d;
    logic signed [W-1:0]      xs, ws;
    logic signed [2*W-1:0]    prod;
    logic                     last;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign last      = idx_q == IW'(N - 1);
    assign prod      = xs * ws;

    always_comb begin
        xs = '0;
        ws = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                xs = x_q[i*W +: W];
                ws = w_q[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        x_d     = x_q;
        w_d     = w_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = MAC;
                x_d     = x;
                w_d     = w;
                idx_d   = '0;
                acc_d   = ACC_W'($signed(bias)) <<< QN;
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = last ? '0 : idx_q + IW'(1);
                if (last) begin
                    state_d = DONE;
                    // Result is registered on the final MAC edge so it is valid with out_valid.
                    sum_d   = W'(sat_qmqn(64'(acc_d >>> QN), W));
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            x_q     <= x_d;
            w_q     <= w_d;
        end
    end

endmodule
